icache: RTL

Direct-mapped, one-word-per-line instruction cache between the instruction fetcher and the memory controller's instruction-fetch port. It serves fetcher requests from an on-chip array on a hit. On a miss it issues a 4-byte fetch to the memory controller, fills the line, and returns the word. It tolerates rollback while a memory fetch is outstanding by completing the fill and suppressing the response.

---
 rtl/icache.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache; hits answer 1 cycle after acceptance, misses 1 cycle after mem_done.
// rdy low freezes every register. With ICACHE_ARRAY_EN undefined, no arrays are built and every request misses.
module icache #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rollback,
   input  logic        fetch_en,
   input  logic [31:0] fetch_pc,
   output logic        fetch_hit,
   output logic [31:0] fetch_inst,
   output logic        mem_en,
   output logic [31:0] mem_pc,
   input  logic        mem_done,
   input  logic [31:0] mem_data
);
   typedef enum logic {IDLE, MISS} state_t;

   state_t      state_q, state_d;
   logic        discard_q, discard_d;
   logic        fetch_hit_q, fetch_hit_d;
   logic [31:0] fetch_inst_q, fetch_inst_d;
   logic        mem_en_q, mem_en_d;
   logic [31:0] mem_pc_q, mem_pc_d;

   logic        accept;
   logic        lookup_hit;
   logic [31:0] hit_data;
   logic        fill;
   logic [1:0]  unused_pc_lsb;

   // Blocking on fetch_hit_q turns the response cycle into a bubble for the still-held request.
   assign accept        = fetch_en && !rollback && !fetch_hit_q;
   assign unused_pc_lsb = fetch_pc[1:0];

`ifdef ICACHE_ARRAY_EN
   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 30 - INDEX_BITS;

   logic [LINES-1:0]      valid_q, valid_d;
   logic [TAG_W-1:0]      tag_mem  [LINES];
   logic [31:0]           data_mem [LINES];
   logic [INDEX_BITS-1:0] req_idx, fill_idx;
   logic [TAG_W-1:0]      req_tag, fill_tag;

   assign req_idx    = fetch_pc[INDEX_BITS+1:2];
   assign req_tag    = fetch_pc[31:INDEX_BITS+2];
   // The outstanding miss address doubles as the latched fill tag/index.
   assign fill_idx   = mem_pc_q[INDEX_BITS+1:2];
   assign fill_tag   = mem_pc_q[31:INDEX_BITS+2];
   assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign hit_data   = data_mem[req_idx];

   always_comb begin
      valid_d = valid_q;
      if (fill) begin
         valid_d[fill_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fill) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= mem_data;
      end
   end
`else
   localparam int unused_index_bits = INDEX_BITS;
   logic unused_fill;

   assign lookup_hit  = 1'b0;
   assign hit_data    = '0;
   assign unused_fill = fill;
`endif

   always_comb begin
      state_d      = state_q;
      discard_d    = discard_q;
      fetch_hit_d  = fetch_hit_q;
      fetch_inst_d = fetch_inst_q;
      mem_en_d     = mem_en_q;
      mem_pc_d     = mem_pc_q;
      fill         = 1'b0;
      if (rdy) begin
         fetch_hit_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (lookup_hit) begin
                     fetch_inst_d = hit_data;
                     fetch_hit_d  = 1'b1;
                  end else begin
                     mem_pc_d  = {fetch_pc[31:2], 2'b00};
                     mem_en_d  = 1'b1;
                     discard_d = 1'b0;
                     state_d   = MISS;
                  end
               end
            end
            MISS: begin
               // The request stays up after a rollback; the controller may already own it.
               if (rollback) begin
                  discard_d = 1'b1;
               end
               if (mem_done) begin
                  fill     = 1'b1;
                  mem_en_d = 1'b0;
                  if (!discard_q && !rollback) begin
                     fetch_inst_d = mem_data;
                     fetch_hit_d  = 1'b1;
                  end
                  state_d = IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         discard_q    <= 1'b0;
         fetch_hit_q  <= 1'b0;
         fetch_inst_q <= '0;
         mem_en_q     <= 1'b0;
         mem_pc_q     <= '0;
      end else begin
         state_q      <= state_d;
         discard_q    <= discard_d;
         fetch_hit_q  <= fetch_hit_d;
         fetch_inst_q <= fetch_inst_d;
         mem_en_q     <= mem_en_d;
         mem_pc_q     <= mem_pc_d;
      end
   end

   assign fetch_hit  = fetch_hit_q;
   assign fetch_inst = fetch_inst_q;
   assign mem_en     = mem_en_q;
   assign mem_pc     = mem_pc_q;
endmodule
